// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch side:
// loader state encoding and the text-segment base address.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

endpackage

// File: rtl/program_loader.sv
// Byte-stream to instruction-RAM writer: assembles big-endian 32-bit words
// and writes them at consecutive word addresses from BASE_ADDRESS.
//
// Byte handshake: a byte is consumed on a rising clk edge where Byte_Valid_i
// and Byte_Ready_o are both 1; the source must hold Byte_i/Byte_Valid_i
// stable until that edge. Byte_Ready_o depends only on registered state.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(TEXT_BASE)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            Start_i,
  input  logic [$clog2(MEMORY_DEPTH):0]   Word_Count_i,
  input  logic [7:0]                      Byte_i,
  input  logic                            Byte_Valid_i,
  output logic                            Byte_Ready_o,
  output logic                            Mem_Write_o,
  output logic [DATA_WIDTH-1:0]           Mem_Address_o,
  output logic [DATA_WIDTH-1:0]           Mem_Data_o,
  output logic                            Busy_o,
  output logic                            Done_o,
  output logic                            Error_o,
  output state_t                          dbg_state_o
);

  localparam int IW = $clog2(MEMORY_DEPTH);
  localparam int CW = IW + 1;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [IW-1:0]           index_q, index_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic                    mem_write_q, mem_write_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_write_d = 1'b0;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      IDLE, DONE: begin
        if (Start_i) begin
          if ((Word_Count_i == '0) || (Word_Count_i > CW'(MEMORY_DEPTH))) begin
            state_d = DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d    = RECV;
            count_d    = Word_Count_i;
            index_d    = '0;
            byte_cnt_d = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
          end
        end
      end
      RECV: begin
        // Byte_Ready_o is 1 throughout RECV, so valid alone completes a handshake.
        if (Byte_Valid_i) begin
          word_d     = {word_q[DATA_WIDTH-9:0], Byte_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
          end
        end
      end
      WRITE: begin
        index_d    = index_q + 1'b1;
        byte_cnt_d = '0;
        if ({1'b0, index_q} == (count_q - CW'(1))) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      index_q     <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_write_q <= mem_write_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Word address is zero-extended index*4 above the base; it cannot wrap.
  assign Mem_Address_o = BASE_ADDRESS + DATA_WIDTH'({index_q, 2'b00});
  assign Mem_Data_o    = word_q;
  assign Mem_Write_o   = mem_write_q;
  assign Byte_Ready_o  = (state_q == RECV);
  assign Busy_o        = (state_q == RECV) || (state_q == WRITE);
  assign Done_o        = done_q;
  assign Error_o       = error_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/program_loader.md
# program_loader

Sequential writer for the instruction memory. It receives a byte stream through a valid/ready handshake, assembles 32-bit instruction words, and issues one write per word to the instruction RAM at byte addresses starting at the text-segment base 0x0040_0000. It is the write side of the word-indexed fetch path: after a load, the fetch side reads the same words at the same byte addresses. It sits between the host byte link (UART receive FIFO) and the instruction RAM write port.

## Interface
Parameters:
- MEMORY_DEPTH, 64, number of 32-bit words in the instruction memory
- DATA_WIDTH, 32, instruction and address width
- BASE_ADDRESS, 32'h0040_0000, byte address of word 0

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- Start_i  in  1  one-cycle request to begin a load session
- Word_Count_i  in  $clog2(MEMORY_DEPTH)+1  number of words to load, sampled on accepted Start_i
- Byte_i  in  8  stream byte
- Byte_Valid_i  in  1  Byte_i valid
- Byte_Ready_o  out  1  loader can accept a byte
- Mem_Write_o  out  1  one-cycle write strobe
- Mem_Address_o  out  DATA_WIDTH  byte address = BASE_ADDRESS + 4*index
- Mem_Data_o  out  DATA_WIDTH  assembled instruction word
- Busy_o  out  1  session in progress
- Done_o  out  1  session finished; held until next accepted Start_i
- Error_o  out  1  last session rejected; held until next accepted Start_i

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE: Start_i accepted. If Word_Count_i == 0 or Word_Count_i > MEMORY_DEPTH, go to DONE with Error_o=1 and issue no writes. Otherwise latch the count, clear the index and byte counter, clear Done_o/Error_o, and go to RECV.
- RECV: Byte_Ready_o=1. On Byte_Valid_i && Byte_Ready_o, shift the byte into the word register, big-endian: the first byte lands in [31:24] and the fourth in [7:0]. On the 4th accepted byte, go to WRITE.
- WRITE: Byte_Ready_o=0. Mem_Write_o=1 for exactly one cycle, with Mem_Address_o and Mem_Data_o valid in the same cycle. Then increment the index. If the written index equals count-1, go to DONE with Done_o=1; otherwise go to RECV with the byte counter at 0.
- Start_i is ignored in RECV and WRITE.
- Busy_o = (state == RECV or WRITE).
- Index width is $clog2(MEMORY_DEPTH). The address is computed as BASE_ADDRESS + {index, 2'b00}, zero-extended to DATA_WIDTH, so it never wraps.
- Bytes offered outside RECV are not consumed. Byte_Ready_o=0 there, so the source must hold them.

## Timing
- Reset values: state IDLE, Byte_Ready_o=0, Mem_Write_o=0, Mem_Address_o=BASE_ADDRESS, Mem_Data_o=0, Busy_o=0, Done_o=0, Error_o=0.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- An accepted Start_i moves to RECV on the next edge, so Byte_Ready_o rises 1 cycle after Start_i.
- Mem_Write_o asserts in the cycle after the 4th byte handshake.
- Peak throughput is 1 word per 5 cycles (4 byte cycles + 1 WRITE cycle).
- Done_o rises the cycle after the last Mem_Write_o.
- Error_o rises 1 cycle after the rejected Start_i.
- Reset asserted mid-session aborts immediately. Any partial word is discarded, and words already written stay in memory.

## Structure
- Shared package: state encoding (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3) and TEXT_BASE=32'h0040_0000, also used by the fetch side.
- Single module with no sub-modules. The byte shifter, counters and FSM live in one file.

## Test plan
- Reset: assert reset mid-RECV after 2 bytes. All outputs return to reset values; the next Start_i restarts cleanly at index 0.
- Single word: Start_i, Word_Count_i=1, bytes 20,08,00,05 with valid held high. Exactly one Mem_Write_o, Address 0x0040_0000, Data 0x2008_0005. Done_o=1 the next cycle.
- Full memory: Word_Count_i=64, random words. 64 writes, last address 0x0040_00FC. Readback via (addr-0x0040_0000)>>2 matches every word.
- Backpressure/gaps: Byte_Valid_i toggled randomly. Word contents are unchanged and no byte is lost or duplicated. Byte_Ready_o=0 during every WRITE cycle.
- Rejects: Word_Count_i=0 and Word_Count_i=65. Error_o=1, Done_o=1, and no Mem_Write_o. A later valid Start_i clears Error_o.
- Start while busy: pulse Start_i during RECV with a different count. It is ignored, and the original count of writes completes.
